serial_data_receiver: RTL and testbench

Receiving end of the team's 10-bit serial frame link. Frame on the wire, one bit per `clk`, MSB first:
- start bit `1`
- 7 data bits, d6 first
- even-parity bit (`^data`)
- stop bit `1`

The line idles at `0`. The block sits on the same clock as the transmitter. It deserialises each frame, checks parity and stop bit, and presents the 7-bit word with a one-cycle valid pulse. It also keeps saturating good-frame and error-frame counters for link monitoring.

---
 rtl/serial_data_receiver_if.sv | 19 +
 rtl/serial_data_receiver.sv | 123 ++++++++++++
 tb/tb_serial_data_receiver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_data_receiver_if.sv
// Serial frame link bundle: line input plus deserialised word and status pulses.
interface serial_data_receiver_if;
   logic       serial_in;
   logic [6:0] out_data;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   modport master (
      output serial_in,
      input  out_data, data_valid, parity_err, frame_err, busy
   );

   modport slave (
      input  serial_in,
      output out_data, data_valid, parity_err, frame_err, busy
   );
endinterface

// File: rtl/serial_data_receiver.sv
// Receiver for the 10-bit serial frame (start, 7 data MSB first, even parity, stop)
// with saturating good/error frame counters.
module serial_data_receiver #(
   parameter int unsigned CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cnt_clr,
   serial_data_receiver_if.slave bus,
   output logic [CNT_W-1:0]     good_cnt,
   output logic [CNT_W-1:0]     err_cnt
);

   localparam int unsigned DATA_W = 7;
   localparam int unsigned IDX_W  = 3;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]        state_q,  state_nxt;
   logic [IDX_W-1:0]  idx_q,    idx_nxt;
   logic [DATA_W-1:0] shift_q,  shift_nxt;
   logic              par_q,    par_nxt;
   logic [DATA_W-1:0] out_nxt;
   logic              dv_nxt, pe_nxt, fe_nxt, busy_nxt;
   logic [CNT_W-1:0]  good_nxt, err_nxt;
   logic              good_inc, err_inc;

   // State register and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         shift_q        <= '0;
         par_q          <= 1'b0;
         bus.out_data   <= '0;
         bus.data_valid <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.busy       <= 1'b0;
         good_cnt       <= '0;
         err_cnt        <= '0;
      end else begin
         state_q        <= state_nxt;
         idx_q          <= idx_nxt;
         shift_q        <= shift_nxt;
         par_q          <= par_nxt;
         bus.out_data   <= out_nxt;
         bus.data_valid <= dv_nxt;
         bus.parity_err <= pe_nxt;
         bus.frame_err  <= fe_nxt;
         bus.busy       <= busy_nxt;
         good_cnt       <= good_nxt;
         err_cnt        <= err_nxt;
      end
   end

   // Next-state, datapath and status evaluation
   always_comb begin
      state_nxt = state_q;
      idx_nxt   = idx_q;
      shift_nxt = shift_q;
      par_nxt   = par_q;
      out_nxt   = bus.out_data;
      dv_nxt    = 1'b0;
      pe_nxt    = 1'b0;
      fe_nxt    = 1'b0;
      good_inc  = 1'b0;
      err_inc   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.serial_in) begin
               state_nxt = DATA;
               idx_nxt   = IDX_W'(DATA_W - 1);
            end
         end
         DATA: begin
            shift_nxt = {shift_q[DATA_W-2:0], bus.serial_in};
            if (idx_q == '0) state_nxt = PARITY;
            else             idx_nxt   = idx_q - IDX_W'(1);
         end
         PARITY: begin
            par_nxt   = bus.serial_in;
            state_nxt = STOP;
         end
         STOP: begin
            // A bad stop bit takes precedence over a parity mismatch
            state_nxt = IDLE;
            if (!bus.serial_in) begin
               fe_nxt  = 1'b1;
               err_inc = 1'b1;
            end else if (par_q != ^shift_q) begin
               pe_nxt  = 1'b1;
               err_inc = 1'b1;
            end else begin
               out_nxt  = shift_q;
               dv_nxt   = 1'b1;
               good_inc = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);

      // Clear beats a coincident completion; counts stick at all-ones
      good_nxt = good_cnt;
      err_nxt  = err_cnt;
      if (cnt_clr) begin
         good_nxt = '0;
         err_nxt  = '0;
      end else begin
         if (good_inc && good_cnt != CNT_MAX) good_nxt = good_cnt + CNT_W'(1);
         if (err_inc  && err_cnt  != CNT_MAX) err_nxt  = err_cnt  + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_serial_data_receiver.sv
// Scoreboard bench for serial_data_receiver: expected frame outcomes are queued
// at stimulus time and matched by a monitor against the status pulses.
module tb_serial_data_receiver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cnt_clr;
   logic       cnt_clr2;
   logic [7:0] good_cnt, err_cnt;
   logic [1:0] good_cnt2, err_cnt2;

   serial_data_receiver_if sif1 ();
   serial_data_receiver_if sif2 ();

   serial_data_receiver #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cnt_clr(cnt_clr), .bus(sif1),
      .good_cnt(good_cnt), .err_cnt(err_cnt)
   );

   serial_data_receiver #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .cnt_clr(cnt_clr2), .bus(sif2),
      .good_cnt(good_cnt2), .err_cnt(err_cnt2)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [2:0] pulses;   // {frame_err, parity_err, data_valid}
      logic [6:0] data;
   } exp_t;

   localparam logic [2:0] EV_GOOD = 3'b001;
   localparam logic [2:0] EV_PAR  = 3'b010;
   localparam logic [2:0] EV_FRM  = 3'b100;

   exp_t exp_q[$];
   int   vcyc[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int id, input logic [2:0] p, input logic [6:0] d);
      exp_t e;
      e.id = id; e.pulses = p; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic handle_evt(input int id, input logic [2:0] p, input logic [6:0] d);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_evt: dut%0d pulses %b data %h, expected none", id, p, d);
      end else begin
         e = exp_q.pop_front();
         if (e.id != id || e.pulses !== p || e.data !== d) begin
            errors++;
            $display("FAIL evt: got dut%0d pulses %b data %h expected dut%0d pulses %b data %h",
                     id, p, d, e.id, e.pulses, e.data);
         end
      end
   endtask

   // Monitor: any status pulse pops one expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if ({sif1.frame_err, sif1.parity_err, sif1.data_valid} != 3'b000)
            handle_evt(1, {sif1.frame_err, sif1.parity_err, sif1.data_valid}, sif1.out_data);
         if (sif1.data_valid) vcyc.push_back(cyc);
         if ({sif2.frame_err, sif2.parity_err, sif2.data_valid} != 3'b000)
            handle_evt(2, {sif2.frame_err, sif2.parity_err, sif2.data_valid}, sif2.out_data);
      end
   end

   task automatic drive(input int id, input logic b);
      if (id == 1) sif1.serial_in = b;
      else         sif2.serial_in = b;
   endtask

   task automatic send_frame(input int id, input logic [6:0] d, input logic par,
                             input logic stop, input int gap, input logic clr_on_stop);
      logic [9:0] w;
      w = {1'b1, d, par, stop};
      for (int i = 9; i >= 0; i--) begin
         if (i == 8) chk("busy_mid", 32'(id == 1 ? sif1.busy : sif2.busy), 32'd1);
         drive(id, w[i]);
         if (i == 0 && clr_on_stop) cnt_clr2 = 1'b1;
         @(negedge clk);
         cnt_clr2 = 1'b0;
      end
      drive(id, 1'b0);
      repeat (gap) @(negedge clk);
   endtask

   task automatic clr_counters();
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
   endtask

   initial begin
      int exp_sat;
      sif1.serial_in = 1'b0;
      sif2.serial_in = 1'b0;
      rst_n    = 1'b0;
      cnt_clr  = 1'b0;
      cnt_clr2 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_data", 32'(sif1.out_data), 32'h0);
      chk("rst_pulses", 32'({sif1.frame_err, sif1.parity_err, sif1.data_valid}), 32'h0);
      chk("rst_busy", 32'(sif1.busy), 32'h0);
      chk("rst_good_cnt", 32'(good_cnt), 32'h0);
      chk("rst_err_cnt", 32'(err_cnt), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single good frame 0x53
      push(1, EV_GOOD, 7'h53);
      send_frame(1, 7'h53, 1'b0, 1'b1, 1, 1'b0);
      chk("t1_out_data", 32'(sif1.out_data), 32'h53);
      chk("t1_good_cnt", 32'(good_cnt), 32'd1);
      chk("t1_err_cnt", 32'(err_cnt), 32'd0);
      chk("t1_busy_idle", 32'(sif1.busy), 32'd0);

      // Back-to-back 0x7F then 0x00
      clr_counters();
      chk("clr_good_cnt", 32'(good_cnt), 32'd0);
      push(1, EV_GOOD, 7'h7F);
      push(1, EV_GOOD, 7'h00);
      send_frame(1, 7'h7F, 1'b1, 1'b1, 0, 1'b0);
      send_frame(1, 7'h00, 1'b0, 1'b1, 1, 1'b0);
      chk("t2_out_data", 32'(sif1.out_data), 32'h00);
      chk("t2_good_cnt", 32'(good_cnt), 32'd2);
      if (vcyc.size() >= 2) chk("t2_valid_gap", 32'(vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2]), 32'd10);
      else                  chk("t2_valid_count", 32'(vcyc.size()), 32'd2);

      // Parity error: out_data holds 0x00
      clr_counters();
      push(1, EV_PAR, 7'h00);
      send_frame(1, 7'h53, 1'b1, 1'b1, 1, 1'b0);
      chk("t3_out_data", 32'(sif1.out_data), 32'h00);
      chk("t3_err_cnt", 32'(err_cnt), 32'd1);
      chk("t3_good_cnt", 32'(good_cnt), 32'd0);

      // Frame error, then good 0x2A
      clr_counters();
      push(1, EV_FRM, 7'h00);
      send_frame(1, 7'h53, 1'b0, 1'b0, 1, 1'b0);
      chk("t4_err_cnt", 32'(err_cnt), 32'd1);
      push(1, EV_GOOD, 7'h2A);
      send_frame(1, 7'h2A, 1'b1, 1'b1, 1, 1'b0);
      chk("t4_out_data", 32'(sif1.out_data), 32'h2A);
      chk("t4_good_cnt", 32'(good_cnt), 32'd1);
      chk("t4_err_cnt2", 32'(err_cnt), 32'd1);

      // Reset in the middle of the data bits
      drive(1, 1'b1); @(negedge clk);
      drive(1, 1'b1); @(negedge clk);
      drive(1, 1'b0); @(negedge clk);
      drive(1, 1'b1); @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_out_data", 32'(sif1.out_data), 32'h0);
      chk("t5_pulses", 32'({sif1.frame_err, sif1.parity_err, sif1.data_valid}), 32'h0);
      chk("t5_busy", 32'(sif1.busy), 32'd0);
      chk("t5_good_cnt", 32'(good_cnt), 32'd0);
      chk("t5_err_cnt", 32'(err_cnt), 32'd0);
      drive(1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(1, EV_GOOD, 7'h11);
      send_frame(1, 7'h11, 1'b0, 1'b1, 1, 1'b0);
      chk("t5_rx_data", 32'(sif1.out_data), 32'h11);
      chk("t5_rx_good", 32'(good_cnt), 32'd1);

      // Saturation on the 2-bit counter instance
      for (int n = 1; n <= 5; n++) begin
         push(2, EV_GOOD, 7'h05);
         send_frame(2, 7'h05, 1'b0, 1'b1, 1, 1'b0);
         exp_sat = (n < 3) ? n : 3;
         chk("t6_sat_cnt", 32'(good_cnt2), 32'(exp_sat));
      end
      chk("t6_err_cnt", 32'(err_cnt2), 32'd0);
      push(2, EV_GOOD, 7'h05);
      send_frame(2, 7'h05, 1'b0, 1'b1, 1, 1'b1);
      chk("t6_clr_wins", 32'(good_cnt2), 32'd0);

      repeat (5) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
